lcd1602_scoreboard_disp: RTL and testbench

- Scoreboard display unit with two functions.
- Drives an HD44780-compatible 1602 character LCD over an 8-bit write-only bus: it runs the init sequence, then continuously refreshes a period line and a team/score line.
- Also provides a combinational BCD-digit to 7-segment decoder for the clock/score digit displays.
- Sits below the scoreboard top level.
- Takes the packed {period, team1_score, team2_score} word and the team-letter byte.

---
 rtl/lcd1602_scoreboard_disp.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd1602_scoreboard_disp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_scoreboard_disp.sv
// lcd1602_scoreboard_disp
//   Scoreboard display unit. Drives an HD44780-compatible 1602 LCD over an
//   8-bit write-only bus. After reset it waits a power-up interval and sends
//   the init commands. It then refreshes two lines forever: a period line and
//   a team/score line. It also holds a combinational BCD to 7-segment decoder.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   disp_lcd   [17:16] period 0..3, [15:8] team1 score, [7:0] team2 score
//   team_name  [7:4] team1 label nibble, [3:0] team2 label nibble
//   digit      value for the 7-segment decoder
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dat        LCD data bus
//   rs         1 = data, 0 = command
//   rw         always 0 (write only)
//   en         LCD enable strobe
module lcd1602_scoreboard_disp #(
  parameter int CLK_DIV       = 50000,
  parameter int POWERUP_STEPS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] disp_lcd,
  input  logic [7:0]  team_name,
  input  logic [3:0]  digit,
  output logic [6:0]  seg,
  output logic [7:0]  dat,
  output logic        rs,
  output logic        rw,
  output logic        en
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  // The index must reach both the last power-up step and character 16.
  localparam int IDX_W = (POWERUP_STEPS > 17) ? $clog2(POWERUP_STEPS) : 5;
  localparam int EN_LO = CLK_DIV / 4;
  localparam int EN_HI = (3 * CLK_DIV) / 4 - 1;

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_INIT,
    ST_LINE1,
    ST_LINE2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             step_end;
  logic             snap_take;
  logic [17:0]      snap_disp;
  logic [7:0]       snap_team;
  logic [3:0]       col;
  logic [7:0]       byte_nxt;
  logic             rs_nxt;
  logic             en_nxt;

  // Scores are binary 0..255 on the bus, but only two digits are shown.
  function automatic logic [6:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  function automatic logic [7:0] tens_ascii(input logic [6:0] v);
    return 8'h30 + 8'(v / 7'd10);
  endfunction

  function automatic logic [7:0] ones_ascii(input logic [6:0] v);
    return 8'h30 + 8'(v % 7'd10);
  endfunction

  // 0-9 map to '0'..'9', 10-15 map to 'A'..'F'.
  function automatic logic [7:0] label_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  function automatic logic [7:0] line1_char(input logic [3:0] c, input logic [1:0] period);
    case (c)
      4'd0:    return 8'h50;                    // P
      4'd1:    return 8'h45;                    // E
      4'd2:    return 8'h52;                    // R
      4'd3:    return 8'h49;                    // I
      4'd4:    return 8'h4F;                    // O
      4'd5:    return 8'h44;                    // D
      4'd7:    return 8'h31 + {6'd0, period};   // period 0..3 shown as 1..4
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] line2_char(input logic [3:0] c, input logic [17:0] d,
                                            input logic [7:0] t);
    logic [6:0] s1;
    logic [6:0] s2;
    s1 = sat99(d[15:8]);
    s2 = sat99(d[7:0]);
    case (c)
      4'd0:    return label_ascii(t[7:4]);
      4'd1:    return 8'h3A;
      4'd2:    return tens_ascii(s1);
      4'd3:    return ones_ascii(s1);
      4'd8:    return label_ascii(t[3:0]);
      4'd9:    return 8'h3A;
      4'd10:   return tens_ascii(s2);
      4'd11:   return ones_ascii(s2);
      default: return 8'h20;
    endcase
  endfunction

  assign rw       = 1'b0;
  assign step_end = (cnt == CNT_W'(CLK_DIV - 1));
  assign cnt_nxt  = step_end ? '0 : cnt + 1'b1;
  assign snap_take = (cnt == '0) && (state == ST_LINE1) && (idx == '0);
  assign col      = 4'(idx - IDX_W'(1));

  // Step timing: cnt counts clocks within one LCD byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= ST_POWERUP;
      idx   <= '0;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (step_end) begin
      idx_nxt = idx + 1'b1;
      case (state)
        ST_POWERUP: if (idx == IDX_W'(POWERUP_STEPS - 1)) begin
          state_nxt = ST_INIT;
          idx_nxt   = '0;
        end
        ST_INIT: if (idx == IDX_W'(3)) begin
          state_nxt = ST_LINE1;
          idx_nxt   = '0;
        end
        ST_LINE1: if (idx == IDX_W'(16)) begin
          state_nxt = ST_LINE2;
          idx_nxt   = '0;
        end
        default: if (idx == IDX_W'(16)) begin
          state_nxt = ST_LINE1;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Byte for the current step. Index 0 of each line is the DDRAM address command.
  always_comb begin
    byte_nxt = 8'h00;
    rs_nxt   = 1'b0;
    case (state)
      ST_INIT: begin
        case (idx[1:0])
          2'd0:    byte_nxt = 8'h38;
          2'd1:    byte_nxt = 8'h0C;
          2'd2:    byte_nxt = 8'h06;
          default: byte_nxt = 8'h01;
        endcase
      end
      ST_LINE1: begin
        if (idx == '0) begin
          byte_nxt = 8'h80;
        end else begin
          rs_nxt   = 1'b1;
          byte_nxt = line1_char(col, snap_disp[17:16]);
        end
      end
      ST_LINE2: begin
        if (idx == '0) begin
          byte_nxt = 8'hC0;
        end else begin
          rs_nxt   = 1'b1;
          byte_nxt = line2_char(col, snap_disp, snap_team);
        end
      end
      default: ;
    endcase
  end

  // Enable strobe is registered so the LCD sees a glitch-free pulse.
  assign en_nxt = (state_nxt != ST_POWERUP) &&
                  (cnt_nxt >= CNT_W'(EN_LO)) && (cnt_nxt <= CNT_W'(EN_HI));

  // Bus stage: dat/rs load at count 0 and stay put across both en edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= 8'h00;
      rs  <= 1'b0;
      en  <= 1'b0;
    end else begin
      if (cnt == '0) begin
        dat <= byte_nxt;
        rs  <= rs_nxt;
      end
      en <= en_nxt;
    end
  end

  // One snapshot per refresh, taken on the 0x80 step, so the lines never tear.
  always_ff @(posedge clk) begin
    if (snap_take) begin
      snap_disp <= disp_lcd;
      snap_team <= team_name;
    end
  end

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_lcd1602_scoreboard_disp.sv
// tb_lcd1602_scoreboard_disp
//   Directed bench for lcd1602_scoreboard_disp with CLK_DIV=8, POWERUP_STEPS=20.
module tb_lcd1602_scoreboard_disp;

  logic        clk;
  logic        rst_n;
  logic [17:0] disp_lcd;
  logic [7:0]  team_name;
  logic [3:0]  digit;
  logic [6:0]  seg;
  logic [7:0]  dat;
  logic        rs;
  logic        rw;
  logic        en;

  int errors = 0;
  int checks = 0;
  int dat_glitch = 0;
  logic       en_d = 1'b0;
  logic [7:0] dat_d = 8'h00;
  logic [8:0] q[$];

  lcd1602_scoreboard_disp #(
    .CLK_DIV      (8),
    .POWERUP_STEPS(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .disp_lcd (disp_lcd),
    .team_name(team_name),
    .digit    (digit),
    .seg      (seg),
    .dat      (dat),
    .rs       (rs),
    .rw       (rw),
    .en       (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture {rs,dat} on each en rising edge; flag any dat change while en is high.
  always @(negedge clk) begin
    if (en && !en_d) q.push_back({rs, dat});
    if (en && en_d && (dat != dat_d)) dat_glitch++;
    en_d  = en;
    dat_d = dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic get_byte(input string tag, output logic [8:0] b);
    int n;
    n = 0;
    while (q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no en pulse within 400 cycles", tag);
      b = 9'h1FF;
    end else begin
      b = q.pop_front();
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] cmd);
    logic [8:0] b;
    get_byte(tag, b);
    check(tag, {23'd0, b}, {24'd0, cmd});
  endtask

  task automatic expect_chars(input string tag, input string s, input int lo, input int hi);
    logic [8:0] b;
    for (int i = lo; i <= hi; i++) begin
      get_byte($sformatf("%s_c%0d", tag, i), b);
      check($sformatf("%s_c%0d", tag, i), {23'd0, b}, {23'd0, 1'b1, s[i]});
    end
  endtask

  task automatic expect_powerup(input string tag);
    int hits;
    hits = 0;
    repeat (160) begin
      @(negedge clk);
      if (en) hits++;
    end
    check({tag, "_en_low"}, hits, 0);
    check({tag, "_no_bytes"}, q.size(), 0);
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                               7'h7F, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    int n;
    rst_n     = 1'b0;
    digit     = 4'd0;
    disp_lcd  = {2'd1, 8'd42, 8'd7};
    team_name = 8'hAB;
    repeat (3) @(negedge clk);
    check("rst_dat", {24'd0, dat}, 32'h00);
    check("rst_rs", {31'd0, rs}, 32'd0);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd0);
    rst_n = 1'b1;

    expect_powerup("pwr");
    expect_cmd("init0", 8'h38);
    expect_cmd("init1", 8'h0C);
    expect_cmd("init2", 8'h06);
    expect_cmd("init3", 8'h01);

    // Refresh 1: period 2, A:42 B:07
    expect_cmd("r1_l1cmd", 8'h80);
    expect_chars("r1_l1", "PERIOD 2        ", 0, 15);
    expect_cmd("r1_l2cmd", 8'hC0);
    expect_chars("r1_l2", "A:42    B:07    ", 0, 15);

    // Refresh 2: labels and scores exchanged
    team_name = 8'hBA;
    disp_lcd  = {2'd1, 8'd7, 8'd42};
    expect_cmd("r2_l1cmd", 8'h80);
    expect_chars("r2_l1", "PERIOD 2        ", 0, 15);
    expect_cmd("r2_l2cmd", 8'hC0);
    expect_chars("r2_l2", "B:07    A:42    ", 0, 15);

    // Refresh 3: team1 score clamps to 99; inputs change halfway through line 2
    team_name = 8'hAB;
    disp_lcd  = {2'd0, 8'd150, 8'd7};
    expect_cmd("r3_l1cmd", 8'h80);
    expect_chars("r3_l1", "PERIOD 1        ", 0, 15);
    expect_cmd("r3_l2cmd", 8'hC0);
    expect_chars("r3_l2", "A:99    B:07    ", 0, 7);
    team_name = 8'h12;
    disp_lcd  = {2'd3, 8'd5, 8'd60};
    expect_chars("r3_l2", "A:99    B:07    ", 8, 15);

    // Refresh 4: new snapshot takes effect
    expect_cmd("r4_l1cmd", 8'h80);
    expect_chars("r4_l1", "PERIOD 4        ", 0, 15);
    expect_cmd("r4_l2cmd", 8'hC0);
    expect_chars("r4_l2", "1:05    2:60    ", 0, 15);

    check("dat_stable_under_en", dat_glitch, 0);

    for (int i = 0; i < 16; i++) begin
      digit = 4'(i);
      #1;
      check($sformatf("seg_%0d", i), {25'd0, seg}, {25'd0, seg_tab[i]});
    end

    // Reset in the middle of an en pulse
    n = 0;
    while (!en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst_en_seen", {31'd0, en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_en", {31'd0, en}, 32'd0);
    check("midrst_dat", {24'd0, dat}, 32'h00);
    check("midrst_rs", {31'd0, rs}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    expect_powerup("pwr2");
    expect_cmd("reinit0", 8'h38);
    expect_cmd("reinit1", 8'h0C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
